// File: rtl/regbank_wb.sv
// regbank_wb -- write-back register bank sitting between the execution units'
// result bus and the operand-fetch stage.
//
// Holds x1..x31 (32 bits each); x0 is hardwired to zero. Results arrive with
// a path tag. A result is accepted only when its tag matches cur_tag.
// Results from a squashed path are dropped without any side effects.
// An accepted result with a one-hot addrW mask writes the selected register.
// An accepted taken jump advances cur_tag.
//
// Parameters:
//   TAG_W  width of the path tag
//   CNT_W  width of the retired-result counter
//
// Ports:
//   clk        core clock, all state updates on posedge
//   reset      synchronous, active-high
//   res_valid  result bus carries a result this cycle
//   res_data   result value
//   res_tag    path tag of the result
//   res_jump   result is a taken branch/jump (advances the path tag)
//   addrW      one-hot destination mask, bit k-1 selects xk; zero = no dest
//   addrA/B    read port addresses
//   dataA/B    read port data, one cycle after the address
//   we         a register write committed in the previous cycle
//   cur_tag    current valid path tag
//   retired    count of accepted results (wraps)
//   mask_err   sticky: an accepted result carried a multi-bit addrW
//
// Configuration macro:
//   REGBANK_BYPASS_EN  defined   -> same-cycle write/read returns the new data (write-first)
//                      undefined -> same-cycle read returns the old data (read-first)
module regbank_wb #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  input  logic [31:0]      res_data,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_jump,
  input  logic [30:0]      addrW,
  input  logic [4:0]       addrA,
  input  logic [4:0]       addrB,
  output logic [31:0]      dataA,
  output logic [31:0]      dataB,
  output logic             we,
  output logic [TAG_W-1:0] cur_tag,
  output logic [CNT_W-1:0] retired,
  output logic             mask_err
);

  // Entry 0 exists only to make the read mux uniform; it is never written.
  logic [31:0]      reg_file [32];
  logic [31:0]      data_a_reg;
  logic [31:0]      data_b_reg;
  logic             we_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             mask_err_reg;

  logic        accept;
  logic        mask_nonzero;
  logic        mask_onehot;
  logic        do_write;
  logic [31:0] wr_hit;
  logic [31:0] rd_a_next;
  logic [31:0] rd_b_next;

  assign accept       = res_valid && (res_tag == tag_reg);
  assign mask_nonzero = |addrW;
  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  assign mask_onehot  = mask_nonzero && ((addrW & (addrW - 31'd1)) == 31'd0);
  assign do_write     = accept && mask_onehot;

  // Per-register write strobe. Register 0 never matches.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_hit
      if (gi == 0) begin : g_zero
        assign wr_hit[gi] = 1'b0;
      end else begin : g_reg
        assign wr_hit[gi] = do_write && addrW[gi-1];
      end
    end
  endgenerate

  always_comb begin
    rd_a_next = '0;
    rd_b_next = '0;
    if (addrA != 5'd0) begin
`ifdef REGBANK_BYPASS_EN
      rd_a_next = wr_hit[addrA] ? res_data : reg_file[addrA];
`else
      rd_a_next = reg_file[addrA];
`endif
    end
    if (addrB != 5'd0) begin
`ifdef REGBANK_BYPASS_EN
      rd_b_next = wr_hit[addrB] ? res_data : reg_file[addrB];
`else
      rd_b_next = reg_file[addrB];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        reg_file[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_hit[i]) begin
          reg_file[i] <= res_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_a_reg   <= '0;
      data_b_reg   <= '0;
      we_reg       <= 1'b0;
      tag_reg      <= '0;
      retired_reg  <= '0;
      mask_err_reg <= 1'b0;
    end else begin
      data_a_reg <= rd_a_next;
      data_b_reg <= rd_b_next;
      we_reg     <= do_write;
      if (accept) begin
        retired_reg <= retired_reg + CNT_W'(1);
        if (res_jump) begin
          tag_reg <= tag_reg + TAG_W'(1);
        end
        if (mask_nonzero && !mask_onehot) begin
          mask_err_reg <= 1'b1;
        end
      end
    end
  end

  assign dataA    = data_a_reg;
  assign dataB    = data_b_reg;
  assign we       = we_reg;
  assign cur_tag  = tag_reg;
  assign retired  = retired_reg;
  assign mask_err = mask_err_reg;

endmodule

// File: tb/tb_regbank_wb.sv
// Directed testbench for regbank_wb. Inputs change #1 after a rising edge and
// outputs are sampled #1 after the following rising edge.
module tb_regbank_wb;

  localparam int TAG_W = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             res_valid;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_jump;
  logic [30:0]      addrW;
  logic [4:0]       addrA;
  logic [4:0]       addrB;
  logic [31:0]      dataA;
  logic [31:0]      dataB;
  logic             we;
  logic [TAG_W-1:0] cur_tag;
  logic [CNT_W-1:0] retired;
  logic             mask_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  regbank_wb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_tag  (res_tag),
    .res_jump (res_jump),
    .addrW    (addrW),
    .addrA    (addrA),
    .addrB    (addrB),
    .dataA    (dataA),
    .dataB    (dataB),
    .we       (we),
    .cur_tag  (cur_tag),
    .retired  (retired),
    .mask_err (mask_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_valid = 1'b0;
    res_jump  = 1'b0;
    addrW     = '0;
    res_data  = '0;
  endtask

  task automatic send(input logic [TAG_W-1:0] t, input logic j,
                      input logic [30:0] m, input logic [31:0] d);
    res_valid = 1'b1;
    res_tag   = t;
    res_jump  = j;
    addrW     = m;
    res_data  = d;
  endtask

  logic [31:0] exp_hz;

  initial begin
    reset = 1'b1;
    res_tag = '0;
    addrA = 5'd5;
    addrB = 5'd7;
    idle();

    // T1: reset state
    step(); step();
    reset = 1'b0;
    check_val("t1_we", {31'd0, we}, 32'd0);
    check_val("t1_tag", {28'd0, cur_tag}, 32'd0);
    check_val("t1_retired", retired, 32'd0);
    check_val("t1_mask_err", {31'd0, mask_err}, 32'd0);
    check_val("t1_dataA", dataA, 32'd0);
    check_val("t1_dataB", dataB, 32'd0);
    for (int i = 1; i < 32; i++) begin
      addrA = 5'(i);
      step();
      check_val($sformatf("t1_read_x%0d", i), dataA, 32'd0);
    end

    // T2: write x5, read it back
    addrA = 5'd1;
    send(4'd0, 1'b0, 31'(1) << 4, 32'hDEADBEEF);
    step();
    check_val("t2_we", {31'd0, we}, 32'd1);
    check_val("t2_retired", retired, 32'd1);
    idle();
    addrA = 5'd5;
    step();
    check_val("t2_we_off", {31'd0, we}, 32'd0);
    check_val("t2_dataA_x5", dataA, 32'hDEADBEEF);
    check_val("t2_retired_hold", retired, 32'd1);

    // T3: jump advances tag, stale result dropped, new tag accepted next cycle
    send(4'd0, 1'b1, 31'd0, 32'd0);
    step();
    check_val("t3_tag_adv", {28'd0, cur_tag}, 32'd1);
    check_val("t3_retired_jump", retired, 32'd2);
    check_val("t3_we_nodest", {31'd0, we}, 32'd0);
    send(4'd0, 1'b0, 31'(1) << 5, 32'd7);
    step();
    check_val("t3_stale_we", {31'd0, we}, 32'd0);
    check_val("t3_stale_retired", retired, 32'd2);
    check_val("t3_stale_tag", {28'd0, cur_tag}, 32'd1);
    send(4'd1, 1'b0, 31'(1) << 6, 32'h77);
    addrA = 5'd6;
    step();
    check_val("t3_x6_still0", dataA, 32'd0);
    check_val("t3_newtag_we", {31'd0, we}, 32'd1);
    check_val("t3_newtag_retired", retired, 32'd3);
    idle();
    addrA = 5'd7;
    step();
    check_val("t3_x7", dataA, 32'h77);

    // T4: mid-operation reset, then 16 accepted jumps wrap the tag
    send(4'd1, 1'b1, 31'(1) << 4, 32'h1234);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    check_val("t4_rst_tag", {28'd0, cur_tag}, 32'd0);
    check_val("t4_rst_we", {31'd0, we}, 32'd0);
    addrA = 5'd5;
    step();
    check_val("t4_rst_x5", dataA, 32'd0);
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b1, 31'd0, 32'd0);
      step();
    end
    idle();
    check_val("t4_tag_wrap", {28'd0, cur_tag}, 32'd0);
    check_val("t4_retired", retired, 32'd16);

    // T5: multi-bit mask
    send(4'd0, 1'b0, 31'h3, 32'hFFFFFFFF);
    step();
    idle();
    check_val("t5_we", {31'd0, we}, 32'd0);
    check_val("t5_mask_err", {31'd0, mask_err}, 32'd1);
    check_val("t5_retired", retired, 32'd17);
    addrA = 5'd1;
    addrB = 5'd2;
    step();
    check_val("t5_x1", dataA, 32'd0);
    check_val("t5_x2", dataB, 32'd0);

    // T6: same-cycle write/read hazard on x3
    addrA = 5'd1;
    addrB = 5'd0;
    send(4'd0, 1'b0, 31'(1) << 2, 32'h11);
    step();
    send(4'd0, 1'b0, 31'(1) << 2, 32'h55);
    addrA = 5'd3;
    step();
`ifdef REGBANK_BYPASS_EN
    exp_hz = 32'h55;
`else
    exp_hz = 32'h11;
`endif
    check_val("t6_hazard_dataA", dataA, exp_hz);
    check_val("t6_dataB_x0", dataB, 32'd0);
    idle();
    step();
    check_val("t6_after_dataA", dataA, 32'h55);
    check_val("t6_after_dataB", dataB, 32'd0);
    check_val("t6_mask_err_sticky", {31'd0, mask_err}, 32'd1);
    check_val("t6_retired", retired, 32'd19);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
